// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and default line settings.
// Both the RX core and the TX block import this package.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

   localparam int unsigned DATA_BITS          = 8;
   localparam int unsigned DEFAULT_CLK_HZ     = 100_000_000;
   localparam int unsigned DEFAULT_BAUD       = 9600;
   localparam int unsigned DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every TICK_DIV clocks.
// 'clear' restarts the phase so the receiver can align sampling to a start edge.
module uart_baud_tick #(
   parameter int unsigned TICK_DIV = 651
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, start-glitch rejection,
// one-entry holding register with valid/ready, framing-error and overrun pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
   parameter int unsigned BAUD       = DEFAULT_BAUD,
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned   TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int unsigned   SW       = $clog2(OVERSAMPLE);
   localparam int unsigned   BW       = $clog2(DATA_BITS);
   localparam logic [SW-1:0] MID_S    = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] LAST_S   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   logic                 sync1_q;
   logic                 rx_s_q;
   logic                 prev_q;
   logic [1:0]           fill_q;
   uart_state_e          state_q;
   logic [SW-1:0]        scnt_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 frame_err_q;
   logic                 overrun_q;
   logic                 tick;
   logic                 start_edge;

   // fill_q keeps the reset value of the flops from faking an edge on a line already low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         prev_q  <= 1'b1;
         fill_q  <= 2'd0;
      end else begin
         sync1_q <= rx;
         rx_s_q  <= sync1_q;
         prev_q  <= rx_s_q;
         if (fill_q != 2'd3) begin
            fill_q <= fill_q + 2'd1;
         end
      end
   end

   assign start_edge = (state_q == ST_IDLE) && (fill_q == 2'd3) && prev_q && !rx_s_q;

   uart_baud_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start_edge),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         scnt_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (start_edge) begin
                  state_q <= ST_START;
                  scnt_q  <= '0;
               end
            end

            ST_START: begin
               if (tick) begin
                  if (scnt_q == MID_S) begin
                     scnt_q <= '0;
                     bit_q  <= '0;
                     state_q <= rx_s_q ? ST_IDLE : ST_DATA;
                  end else begin
                     scnt_q <= scnt_q + 1'b1;
                  end
               end
            end

            ST_DATA: begin
               if (tick) begin
                  if (scnt_q == LAST_S) begin
                     scnt_q  <= '0;
                     shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                     if (bit_q == LAST_BIT) begin
                        state_q <= ST_STOP;
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end else begin
                     scnt_q <= scnt_q + 1'b1;
                  end
               end
            end

            ST_STOP: begin
               if (tick) begin
                  if (scnt_q == LAST_S) begin
                     scnt_q <= '0;
                     if (rx_s_q) begin
                        // A consume in this same cycle frees the register for the new byte
                        if (!rx_valid_q || rx_ready) begin
                           rx_data_q  <= shift_q;
                           rx_valid_q <= 1'b1;
                        end else begin
                           overrun_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_BREAK;
                     end
                  end else begin
                     scnt_q <= scnt_q + 1'b1;
                  end
               end
            end

            ST_BREAK: begin
               if (rx_s_q) begin
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
